spi_reg_bridge: RTL and testbench

- Command/register stage directly downstream of the SPI slave byte receiver. Consumes its received-byte/ready strobe and drives its transmit-byte load.
- Decodes a one-byte command per SSEL frame, then streams write data into, or read data out of, an internal register file with address auto-increment.
- Exposes a sideband read port and a write-notify strobe to on-chip logic.

---
 rtl/spi_reg_bridge.sv | 165 ++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_bridge
// Description : Command/register stage behind an SPI slave byte receiver.
//               Each SSEL frame starts with a command byte (bit 7 = read,
//               low bits = start address), then streams write data into or
//               read data out of a 2**ADDR_W x 8 register file. The address
//               auto-increments and wraps. A sideband read port and a
//               write-notify strobe are provided for on-chip logic.
//               Optional macro SPI_REG_ID_EN: address 0 becomes a read-only
//               ID register returning ID_VALUE.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_bridge #(
    parameter int                 ADDR_W   = 4,
    parameter int                 DATA_W   = 8,
    parameter logic [DATA_W-1:0]  ID_VALUE = 8'hA5
) (
    input  logic              clk,
    input  logic              PRESET,
    input  logic              SSEL,
    input  logic [DATA_W-1:0] rx_byte,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] tx_byte,
    output logic              tx_load,
    input  logic [ADDR_W-1:0] cfg_addr,
    output logic [DATA_W-1:0] cfg_rdata,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
);

`ifdef SPI_REG_ID_EN
    localparam logic c_ID_EN = 1'b1;
`else
    localparam logic c_ID_EN = 1'b0;
`endif

    localparam int         c_NREG     = 2**ADDR_W;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_CMD   = 2'd1;
    localparam logic [1:0] c_ST_WRITE = 2'd2;
    localparam logic [1:0] c_ST_READ  = 2'd3;

    logic              r_ssel_meta;
    logic              r_ssel_sync;
    logic              r_ssel_act_d;
    logic              w_ssel_act;
    logic              w_open;
    logic              w_close;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_regs [c_NREG];
    logic [DATA_W-1:0] r_tx_byte;
    logic              r_tx_load;
    logic              r_wr_pulse;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    logic [ADDR_W-1:0] w_cmd_addr;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [DATA_W-1:0] w_rd_cmd;
    logic [DATA_W-1:0] w_rd_inc;
    logic              w_wr_blocked;

    assign w_ssel_act   = ~r_ssel_sync;
    assign w_open       = w_ssel_act & ~r_ssel_act_d;
    assign w_close      = ~w_ssel_act & r_ssel_act_d;
    assign w_cmd_addr   = rx_byte[ADDR_W-1:0];
    assign w_addr_inc   = r_addr + 1'b1;
    assign w_wr_blocked = c_ID_EN && (r_addr == '0);

    // Read muxes: command start address, next streamed address, sideband port
    always_comb begin
        w_rd_cmd  = r_regs[w_cmd_addr];
        w_rd_inc  = r_regs[w_addr_inc];
        cfg_rdata = r_regs[cfg_addr];
        if (c_ID_EN && (w_cmd_addr == '0)) w_rd_cmd  = ID_VALUE;
        if (c_ID_EN && (w_addr_inc == '0)) w_rd_inc  = ID_VALUE;
        if (c_ID_EN && (cfg_addr   == '0)) cfg_rdata = ID_VALUE;
    end

    // Two-flop SSEL synchronizer (idle high) plus edge-detect history
    always_ff @(posedge clk) begin
        if (PRESET) begin
            r_ssel_meta  <= 1'b1;
            r_ssel_sync  <= 1'b1;
            r_ssel_act_d <= 1'b0;
        end else begin
            r_ssel_meta  <= SSEL;
            r_ssel_sync  <= r_ssel_meta;
            r_ssel_act_d <= w_ssel_act;
        end
    end

    // Frame FSM, register file and registered strobes; frame close beats rx_valid
    always_ff @(posedge clk) begin
        if (PRESET) begin
            r_state    <= c_ST_IDLE;
            r_addr     <= '0;
            r_tx_byte  <= '0;
            r_tx_load  <= 1'b0;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            for (int i = 0; i < c_NREG; i++) r_regs[i] <= '0;
        end else begin
            r_tx_load  <= 1'b0;
            r_wr_pulse <= 1'b0;
            if (w_close) begin
                r_state <= c_ST_IDLE;
                r_addr  <= '0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_open) r_state <= c_ST_CMD;
                    end
                    c_ST_CMD: begin
                        if (rx_valid) begin
                            r_addr <= w_cmd_addr;
                            if (rx_byte[DATA_W-1]) begin
                                r_state   <= c_ST_READ;
                                r_tx_load <= 1'b1;
                                r_tx_byte <= w_rd_cmd;
                            end else begin
                                r_state <= c_ST_WRITE;
                            end
                        end
                    end
                    c_ST_WRITE: begin
                        if (rx_valid) begin
                            r_addr <= w_addr_inc;
                            if (!w_wr_blocked) begin
                                r_regs[r_addr] <= rx_byte;
                                r_wr_pulse     <= 1'b1;
                                r_wr_addr      <= r_addr;
                                r_wr_data      <= rx_byte;
                            end
                        end
                    end
                    c_ST_READ: begin
                        // Incoming byte is a dummy; only its arrival matters
                        if (rx_valid) begin
                            r_addr    <= w_addr_inc;
                            r_tx_load <= 1'b1;
                            r_tx_byte <= w_rd_inc;
                        end
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    assign tx_byte  = r_tx_byte;
    assign tx_load  = r_tx_load;
    assign wr_pulse = r_wr_pulse;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign busy     = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_bridge
// Description : Self-checking bench for spi_reg_bridge. Table of SPI frames
//               with expected write/transmit events fed through a scoreboard,
//               plus hand-written wrap, abort, close-collision and reset
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_bridge;

    logic       clk = 1'b0;
    logic       PRESET = 1'b1;
    logic       SSEL = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic [3:0] cfg_addr = 4'h0;
    logic [7:0] cfg_rdata;
    logic       wr_pulse;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    spi_reg_bridge #(.ADDR_W(4), .DATA_W(8), .ID_VALUE(8'hA5)) dut (
        .clk(clk), .PRESET(PRESET), .SSEL(SSEL),
        .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_byte(tx_byte), .tx_load(tx_load),
        .cfg_addr(cfg_addr), .cfg_rdata(cfg_rdata),
        .wr_pulse(wr_pulse), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit         is_wr;
        logic [3:0] a;
        logic [7:0] d;
    } ev_t;
    ev_t q[$];

    // Frame record: writes send cmd,b0,b1 -> two write events (ea,ed);
    // reads send cmd,dummy -> two transmit events (ed0, ed1).
    typedef struct {
        logic [7:0] cmd;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [3:0] ea0;
        logic [7:0] ed0;
        logic [3:0] ea1;
        logic [7:0] ed1;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input bit is_wr, input logic [3:0] a, input logic [7:0] d);
        ev_t e;
        e.is_wr = is_wr;
        e.a = a;
        e.d = d;
        q.push_back(e);
    endtask

    logic prev_rv = 1'b0;

    task automatic handle(input bit is_wr, input logic [3:0] a, input logic [7:0] d);
        ev_t e;
        if (!prev_rv) begin
            n_vec++; n_err++;
            $display("FAIL latency: strobe (wr=%0d) without rx_valid one cycle earlier", is_wr);
        end
        if (q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_event: wr=%0d addr=%0h data=%0h, none expected", is_wr, a, d);
        end else begin
            e = q.pop_front();
            chk("ev_kind", {31'd0, is_wr}, {31'd0, e.is_wr});
            chk("ev_data", {24'd0, d}, {24'd0, e.d});
            if (is_wr) chk("ev_addr", {28'd0, a}, {28'd0, e.a});
        end
    endtask

    // Output monitor: strobes are sampled mid-cycle and matched against the queue
    always @(negedge clk) begin
        if (wr_pulse === 1'b1) handle(1'b1, wr_addr, wr_data);
        if (tx_load === 1'b1) handle(1'b0, 4'h0, tx_byte);
        prev_rv = rx_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_frame();
        SSEL = 1'b0;
        repeat (4) tick();
    endtask

    task automatic close_frame();
        SSEL = 1'b1;
        repeat (4) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic cfg_check(input string nm, input logic [3:0] a, input logic [7:0] exp);
        cfg_addr = a;
        #1;
        chk(nm, {24'd0, cfg_rdata}, {24'd0, exp});
    endtask

    task automatic drain_check(input string nm);
        chk(nm, q.size(), 0);
        q.delete();
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "_busy"}, {31'd0, busy}, 0);
        chk({nm, "_tx_byte"}, {24'd0, tx_byte}, 0);
        chk({nm, "_tx_load"}, {31'd0, tx_load}, 0);
        chk({nm, "_wr_pulse"}, {31'd0, wr_pulse}, 0);
        chk({nm, "_wr_addr"}, {28'd0, wr_addr}, 0);
        chk({nm, "_wr_data"}, {24'd0, wr_data}, 0);
        for (int i = 0; i < 16; i++) begin
            cfg_addr = 4'(i);
            #1;
`ifdef SPI_REG_ID_EN
            chk({nm, "_regs"}, {24'd0, cfg_rdata}, (i == 0) ? 32'hA5 : 32'h0);
`else
            chk({nm, "_regs"}, {24'd0, cfg_rdata}, 32'h0);
`endif
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'h03, 8'h11, 8'h22, 4'h3, 8'h11, 4'h4, 8'h22};
        vecs[1] = '{8'h83, 8'h00, 8'h00, 4'h0, 8'h11, 4'h0, 8'h22};
        vecs[2] = '{8'h0A, 8'h5C, 8'hC5, 4'hA, 8'h5C, 4'hB, 8'hC5};
        vecs[3] = '{8'h73, 8'h33, 8'h44, 4'h3, 8'h33, 4'h4, 8'h44};
        vecs[4] = '{8'hFA, 8'h00, 8'h00, 4'h0, 8'h5C, 4'h0, 8'hC5};
        vecs[5] = '{8'h83, 8'h00, 8'h00, 4'h0, 8'h33, 4'h0, 8'h44};
        vecs[6] = '{8'h0E, 8'h01, 8'h02, 4'hE, 8'h01, 4'hF, 8'h02};
        vecs[7] = '{8'h8E, 8'h00, 8'h00, 4'h0, 8'h01, 4'h0, 8'h02};

        repeat (3) tick();
        PRESET = 1'b0;
        tick();
        check_reset_state("reset");

        // Table-driven frames
        for (int v = 0; v < 8; v++) begin
            open_frame();
            chk("busy_open", {31'd0, busy}, 1);
            if (vecs[v].cmd[7]) begin
                push(1'b0, 4'h0, vecs[v].ed0);
                send_byte(vecs[v].cmd);
                push(1'b0, 4'h0, vecs[v].ed1);
                send_byte(vecs[v].b0);
                repeat (3) tick();
                chk("tx_hold", {24'd0, tx_byte}, {24'd0, vecs[v].ed1});
            end else begin
                send_byte(vecs[v].cmd);
                push(1'b1, vecs[v].ea0, vecs[v].ed0);
                send_byte(vecs[v].b0);
                push(1'b1, vecs[v].ea1, vecs[v].ed1);
                send_byte(vecs[v].b1);
                cfg_check("cfg_after_write", vecs[v].ea1, vecs[v].ed1);
            end
            close_frame();
            chk("busy_closed", {31'd0, busy}, 0);
            drain_check("sb_drain_vec");
        end

        // Wrap-around write 15 -> 0
        open_frame();
        send_byte(8'h0F);
        push(1'b1, 4'hF, 8'hAA);
        send_byte(8'hAA);
`ifndef SPI_REG_ID_EN
        push(1'b1, 4'h0, 8'hBB);
`endif
        send_byte(8'hBB);
        close_frame();
        drain_check("sb_drain_wrap");
        cfg_check("wrap_r15", 4'hF, 8'hAA);
`ifdef SPI_REG_ID_EN
        cfg_check("wrap_r0", 4'h0, 8'hA5);
        push(1'b0, 4'h0, 8'hA5);
`else
        cfg_check("wrap_r0", 4'h0, 8'hBB);
        push(1'b0, 4'h0, 8'hBB);
`endif
        // Read back address 0 and then address 1
        open_frame();
        send_byte(8'h80);
        push(1'b0, 4'h0, 8'h00);
        send_byte(8'h5A);
        close_frame();
        drain_check("sb_drain_read0");

        // Abort after command only; next frame's first byte is a command
        open_frame();
        send_byte(8'h05);
        close_frame();
        drain_check("sb_drain_abort");
        cfg_check("abort_r5", 4'h5, 8'h00);
        open_frame();
        send_byte(8'h0B);
        push(1'b1, 4'hB, 8'h77);
        send_byte(8'h77);
        close_frame();
        drain_check("sb_drain_after_abort");
        cfg_check("after_abort_rB", 4'hB, 8'h77);
        cfg_check("after_abort_r5", 4'h5, 8'h00);

        // rx_valid coinciding with frame close during WRITE
        open_frame();
        send_byte(8'h07);
        push(1'b1, 4'h7, 8'h10);
        send_byte(8'h10);
        SSEL = 1'b1;
        tick();
        tick();
        rx_byte = 8'h99;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (3) tick();
        drain_check("sb_drain_collide");
        cfg_check("collide_r7", 4'h7, 8'h10);
        cfg_check("collide_r8", 4'h8, 8'h00);
        chk("collide_busy", {31'd0, busy}, 0);

        // Reset in the middle of a READ burst
        open_frame();
        push(1'b0, 4'h0, 8'h5C);
        send_byte(8'h8A);
        PRESET = 1'b1;
        SSEL = 1'b1;
        tick();
        check_reset_state("midreset");
        PRESET = 1'b0;
        repeat (2) tick();
        drain_check("sb_drain_midreset");

        // Fresh frames after reset behave normally
        open_frame();
        send_byte(8'h0C);
        push(1'b1, 4'hC, 8'h42);
        send_byte(8'h42);
        close_frame();
        open_frame();
        push(1'b0, 4'h0, 8'h42);
        send_byte(8'h8C);
        push(1'b0, 4'h0, 8'h00);
        send_byte(8'hFF);
        close_frame();
        drain_check("sb_drain_post_reset");
        cfg_check("post_reset_rC", 4'hC, 8'h42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
